// File: rtl/numpad_entry.sv
// numpad_entry
// Turns scanner key events into BCD operands and an operator for the calculator
// ALU. It enters operand A, then the operator, then operand B. On '=' it makes
// one valid/ready request. When the result strobe arrives, the result is loaded
// back into A so that operations can chain.
//
// Ports:
//   clock        system clock
//   reset_n      asynchronous active-low reset
//   value        key event: 0 none, 16+k key index k pressed, 1..15 ignored
//   req_valid    ALU request valid (held until req_ready)
//   req_ready    ALU accepts request
//   operand_a    BCD operand A, newest digit in [3:0]
//   operand_b    BCD operand B, newest digit in [3:0]
//   op           operator: 00 add, 01 sub, 10 mul, 11 div
//   result_valid ALU result strobe (single cycle)
//   result       BCD ALU result
//   display      BCD value shown to the user
//   busy         request outstanding (ISSUE or WAIT)
module numpad_entry #(
  parameter int DIGITS = 4
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [4:0]            value,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [4*DIGITS-1:0]   operand_a,
  output logic [4*DIGITS-1:0]   operand_b,
  output logic [1:0]            op,
  input  logic                  result_valid,
  input  logic [4*DIGITS-1:0]   result,
  output logic [4*DIGITS-1:0]   display,
  output logic                  busy
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] FULL = CW'(DIGITS);

  typedef enum logic [1:0] {
    ENTER_A = 2'd0,
    ENTER_B = 2'd1,
    ISSUE   = 2'd2,
    WAIT    = 2'd3
  } state_t;

  // Maps a key index to {is_digit, bcd_digit}. The keypad scan order is not numeric.
  function automatic logic [4:0] key_digit(input logic [3:0] k);
    logic [4:0] r;
    case (k)
      4'd0:    r = 5'b1_0001;
      4'd1:    r = 5'b1_0100;
      4'd2:    r = 5'b1_0111;
      4'd3:    r = 5'b1_0000;
      4'd4:    r = 5'b1_0010;
      4'd5:    r = 5'b1_0101;
      4'd6:    r = 5'b1_1000;
      4'd8:    r = 5'b1_0011;
      4'd9:    r = 5'b1_0110;
      4'd10:   r = 5'b1_1001;
      default: r = 5'b0_0000;
    endcase
    return r;
  endfunction

  // A digit is taken only when there is room and it is not a leading zero.
  function automatic logic digit_ok(input logic [CW-1:0] cnt, input logic [3:0] d);
    return (cnt != FULL) && !((d == 4'd0) && (cnt == {CW{1'b0}}));
  endfunction

  state_t          state_r, state_s;
  logic [W-1:0]    a_r, a_s, b_r, b_s, display_r, display_s;
  logic [W-1:0]    a_base_s;
  logic [1:0]      op_r, op_s;
  logic [CW-1:0]   cnt_r, cnt_s, cnt_base_s;
  logic            fresh_r, fresh_s;
  logic            req_valid_r, req_valid_s;
  logic            busy_r, busy_s;

  logic [4:0]      dig_s;
  logic            is_digit_s, is_clear_s, is_eq_s, is_op_s;

  assign dig_s      = key_digit(value[3:0]);
  assign is_digit_s = value[4] & dig_s[4];
  assign is_clear_s = value[4] & (value[3:0] == 4'd11);
  assign is_eq_s    = value[4] & (value[3:0] == 4'd7);
  assign is_op_s    = value[4] & (value[3:2] == 2'b11);

  // Next-state and next-register computation for the entry state machine.
  always_comb begin
    state_s     = state_r;
    a_s         = a_r;
    b_s         = b_r;
    op_s        = op_r;
    cnt_s       = cnt_r;
    fresh_s     = fresh_r;
    req_valid_s = req_valid_r;
    a_base_s    = a_r;
    cnt_base_s  = cnt_r;

    if (is_clear_s) begin
      // Clear wins even against a request taken in this same cycle.
      // Any result that arrives later is dropped because ENTER_A ignores it.
      state_s     = ENTER_A;
      a_s         = {W{1'b0}};
      b_s         = {W{1'b0}};
      op_s        = 2'b00;
      cnt_s       = {CW{1'b0}};
      fresh_s     = 1'b0;
      req_valid_s = 1'b0;
    end else begin
      case (state_r)
        ENTER_A: begin
          if (is_digit_s) begin
            // After a chained result, the first digit starts a new A.
            if (fresh_r) begin
              a_base_s   = {W{1'b0}};
              cnt_base_s = {CW{1'b0}};
            end else begin
              a_base_s   = a_r;
              cnt_base_s = cnt_r;
            end
            fresh_s = 1'b0;
            if (digit_ok(cnt_base_s, dig_s[3:0])) begin
              a_s   = {a_base_s[W-5:0], dig_s[3:0]};
              cnt_s = cnt_base_s + CW'(1);
            end else begin
              a_s   = a_base_s;
              cnt_s = cnt_base_s;
            end
          end else if (is_op_s) begin
            op_s    = value[1:0];
            b_s     = {W{1'b0}};
            cnt_s   = {CW{1'b0}};
            fresh_s = 1'b0;
            state_s = ENTER_B;
          end else begin
            state_s = ENTER_A;
          end
        end
        ENTER_B: begin
          if (is_digit_s) begin
            if (digit_ok(cnt_r, dig_s[3:0])) begin
              b_s   = {b_r[W-5:0], dig_s[3:0]};
              cnt_s = cnt_r + CW'(1);
            end else begin
              b_s = b_r;
            end
          end else if (is_op_s) begin
            // The operator can still be changed until B has its first digit.
            if (cnt_r == {CW{1'b0}}) begin
              op_s = value[1:0];
            end else begin
              op_s = op_r;
            end
          end else if (is_eq_s) begin
            state_s     = ISSUE;
            req_valid_s = 1'b1;
          end else begin
            state_s = ENTER_B;
          end
        end
        ISSUE: begin
          if (req_valid_r && req_ready) begin
            req_valid_s = 1'b0;
            state_s     = WAIT;
          end else begin
            state_s = ISSUE;
          end
        end
        WAIT: begin
          if (result_valid) begin
            a_s     = result;
            cnt_s   = FULL;
            fresh_s = 1'b1;
            state_s = ENTER_A;
          end else begin
            state_s = WAIT;
          end
        end
        default: begin
          state_s     = ENTER_A;
          req_valid_s = 1'b0;
        end
      endcase
    end
  end

  // The display and busy signals are derived from the next state, so that both outputs are registered.
  always_comb begin
    display_s = (state_s == ENTER_A) ? a_s : b_s;
    busy_s    = (state_s == ISSUE) || (state_s == WAIT);
  end

  // State and datapath registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ENTER_A;
      a_r         <= {W{1'b0}};
      b_r         <= {W{1'b0}};
      op_r        <= 2'b00;
      cnt_r       <= {CW{1'b0}};
      fresh_r     <= 1'b0;
      req_valid_r <= 1'b0;
      display_r   <= {W{1'b0}};
      busy_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      a_r         <= a_s;
      b_r         <= b_s;
      op_r        <= op_s;
      cnt_r       <= cnt_s;
      fresh_r     <= fresh_s;
      req_valid_r <= req_valid_s;
      display_r   <= display_s;
      busy_r      <= busy_s;
    end
  end

  assign req_valid = req_valid_r;
  assign operand_a = a_r;
  assign operand_b = b_r;
  assign op        = op_r;
  assign display   = display_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_numpad_entry.sv
// Testbench for numpad_entry. A decimal-integer reference model tracks the
// operands, the entry phase and the outstanding request. All outputs are
// compared after every clock. There are extra constant checks at the key
// points of the test plan.
module tb_numpad_entry;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;
  localparam int P_A = 0, P_B = 1, P_ISS = 2, P_WAIT = 3;

  logic          clock;
  logic          reset_n;
  logic [4:0]    value;
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  operand_a;
  logic [W-1:0]  operand_b;
  logic [1:0]    op;
  logic          result_valid;
  logic [W-1:0]  result;
  logic [W-1:0]  display;
  logic          busy;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_phase, m_cnt, m_fresh, m_op;
  int m_val[2];                 // [0] = A, [1] = B as decimal integers
  int dmap[16] = '{1, 4, 7, 0, 2, 5, 8, -1, 3, 6, 9, -1, -1, -1, -1, -1};

  numpad_entry #(.DIGITS(DIGITS)) dut (
    .clock(clock), .reset_n(reset_n), .value(value),
    .req_valid(req_valid), .req_ready(req_ready),
    .operand_a(operand_a), .operand_b(operand_b), .op(op),
    .result_valid(result_valid), .result(result),
    .display(display), .busy(busy)
  );

  initial clock = 1'b0;
  always #10 clock = ~clock;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int t;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int from_bcd(input logic [W-1:0] b);
    int v;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
    return v;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = P_A; m_cnt = 0; m_fresh = 0; m_op = 0;
    m_val[0] = 0;  m_val[1] = 0;
  endtask

  task automatic model_digit(input int idx, input int d);
    if (m_cnt < DIGITS && !(d == 0 && m_cnt == 0)) begin
      m_val[idx] = m_val[idx] * 10 + d;
      m_cnt++;
    end
  endtask

  // Applies one cycle of inputs to the model using the behavioural rules.
  task automatic model_step(input int v, input bit rdy, input bit rv, input logic [W-1:0] res);
    int k;
    k = (v >= 16) ? v - 16 : -1;
    if (k == 11) begin
      model_reset();
    end else begin
      case (m_phase)
        P_A: begin
          if (k >= 0 && dmap[k] >= 0) begin
            if (m_fresh != 0) begin m_val[0] = 0; m_cnt = 0; m_fresh = 0; end
            model_digit(0, dmap[k]);
          end else if (k >= 12) begin
            m_op = k - 12; m_val[1] = 0; m_cnt = 0; m_fresh = 0; m_phase = P_B;
          end
        end
        P_B: begin
          if (k >= 0 && dmap[k] >= 0) model_digit(1, dmap[k]);
          else if (k >= 12) begin if (m_cnt == 0) m_op = k - 12; end
          else if (k == 7) m_phase = P_ISS;
        end
        P_ISS: if (rdy) m_phase = P_WAIT;
        P_WAIT: if (rv) begin
          m_val[0] = from_bcd(res); m_cnt = DIGITS; m_fresh = 1; m_phase = P_A;
        end
        default: ;
      endcase
    end
  endtask

  task automatic check_all();
    check("req_valid", 32'(req_valid), 32'(m_phase == P_ISS));
    check("busy", 32'(busy), 32'(m_phase == P_ISS || m_phase == P_WAIT));
    check("operand_a", 32'(operand_a), 32'(to_bcd(m_val[0])));
    check("operand_b", 32'(operand_b), 32'(to_bcd(m_val[1])));
    check("op", 32'(op), 32'(m_op));
    check("display", 32'(display), 32'(to_bcd(m_val[(m_phase == P_A) ? 0 : 1])));
  endtask

  // Drives one cycle of inputs, advances the model, clocks, then compares.
  task automatic step(input int v, input bit rdy = 1'b0, input bit rv = 1'b0,
                      input logic [W-1:0] res = '0);
    value        = 5'(v);
    req_ready    = rdy;
    result_valid = rv;
    result       = res;
    model_step(v, rdy, rv, res);
    @(posedge clock);
    #1;
    check_all();
  endtask

  initial begin
    reset_n = 1'b0; value = 5'd0; req_ready = 1'b0; result_valid = 1'b0; result = '0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_all();
    reset_n = 1'b1;

    // Basic entry
    step(16); step(20);
    check("entry_12", 32'(display), 32'h0012);
    step(19);
    check("entry_120", 32'(display), 32'h0120);

    // Leading zeros, then overflow
    step(27); step(19); step(19);
    check("lead_zero", 32'(display), 32'h0000);
    step(16); step(20); step(24); step(17); step(18);
    check("overflow", 32'(display), 32'h1234);

    // Full operation with handshake
    step(27); step(16); step(20); step(28);
    check("after_add", 32'(display), 32'h0000);
    step(24); step(17);
    check("b_34", 32'(display), 32'h0034);
    step(23);
    check("issue_valid", 32'(req_valid), 32'd1);
    check("issue_a", 32'(operand_a), 32'h0012);
    check("issue_b", 32'(operand_b), 32'h0034);
    repeat (3) begin
      step(0);
      check("hold_valid", 32'(req_valid), 32'd1);
    end
    step(0, 1'b1);
    check("taken_valid", 32'(req_valid), 32'd0);
    check("taken_busy", 32'(busy), 32'd1);
    step(0, 1'b0, 1'b1, 16'h0046);
    check("result_disp", 32'(display), 32'h0046);
    check("result_busy", 32'(busy), 32'd0);

    // Operator replace and chaining
    step(29); step(30);
    check("op_replace", 32'(op), 32'd2);
    step(20); step(23);
    check("chain_a", 32'(operand_a), 32'h0046);
    check("chain_b", 32'(operand_b), 32'h0002);

    // Clear together with an accepted request
    step(27, 1'b1);
    check("clr_valid", 32'(req_valid), 32'd0);
    check("clr_disp", 32'(display), 32'h0000);
    step(0, 1'b0, 1'b1, 16'h9999);
    check("late_result", 32'(display), 32'h0000);

    // Asynchronous reset asserted while a request is pending
    step(16); step(28); step(20); step(23);
    #5;
    reset_n = 1'b0;
    model_reset();
    #1;
    check("areset_valid", 32'(req_valid), 32'd0);
    check("areset_disp", 32'(display), 32'h0000);
    check("areset_busy", 32'(busy), 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Invalid event codes must change nothing
    step(16);
    for (int c = 1; c < 16; c++) step(c);
    check("invalid_codes", 32'(display), 32'h0001);

    // Randomized traffic against the model
    for (int n = 0; n < 600; n++) begin
      int r, v, k;
      r = int'($urandom_range(0, 9));
      if (r < 4) v = 0;
      else if (r < 5) v = int'($urandom_range(1, 15));
      else begin
        k = int'($urandom_range(0, 15));
        if (k == 11 && $urandom_range(0, 3) != 0) k = 7;
        v = 16 + k;
      end
      step(v, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           to_bcd(int'($urandom_range(0, 9999))));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/numpad_entry.md
Name: numpad_entry

Overview:
- Consumes the 5-bit key-event stream produced by the numpad scanner and builds BCD operands and an operator for the calculator datapath.
- Runs a digit-entry state machine for operand A, operator, then operand B.
- On '=', issues one valid/ready request to the ALU, then waits for the result and loads it back as operand A so operations can chain.
- Drives the BCD display word.

Parameters:
DIGITS, 4, maximum BCD digits per operand; operand width W = 4*DIGITS

Ports:
clock  in  1  system clock (50 MHz)
reset_n  in  1  asynchronous active-low reset
value  in  5  key event from scanner: 0 = none; 16+k = key index k pressed (single-cycle pulse); 1..15 are invalid and ignored
req_valid  out  1  ALU request valid
req_ready  in  1  ALU accepts request
operand_a  out  W  BCD operand A, stable while req_valid=1
operand_b  out  W  BCD operand B, stable while req_valid=1
op  out  2  operator: 00 add, 01 sub, 10 mul, 11 div
result_valid  in  1  ALU result strobe, 1 cycle
result  in  W  BCD ALU result
display  out  W  BCD value to show
busy  out  1  high in ISSUE or WAIT

Behaviour:
- Key index map k -> function: 0='1', 1='4', 2='7', 3='0', 4='2', 5='5', 6='8', 7='=' (F), 8='3', 9='6', 10='9', 11=Clear (E), 12=add (A), 13=sub (B), 14=mul (C), 15=div (D).
- Reset: state ENTER_A; operand_a, operand_b, op, display all 0; req_valid=0; busy=0; digit count=0; fresh=0.
- Registers update on the rising edge of clock only. A key event takes effect in the cycle it is present, so outputs change 1 cycle later.
- Digit entry, into the current operand (A in ENTER_A, B in ENTER_B):
  - If count==DIGITS, the digit is ignored.
  - A '0' with count==0 is ignored (no leading zeros).
  - Otherwise operand <= {operand[W-5:0], digit}; count <= count+1.
- Clear (any state): operand_a, operand_b, op, count, fresh <= 0; req_valid <= 0; state <= ENTER_A. Clear has priority over every other event in the same cycle.
- ENTER_A:
  - If fresh=1, a digit first clears A and count, then enters the digit; fresh <= 0.
  - An operator latches op, clears B and count, sets fresh <= 0, and moves to ENTER_B.
  - '=' is ignored.
  - display = A.
- ENTER_B:
  - An operator with count==0 replaces op; an operator with count>0 is ignored.
  - '=' moves to ISSUE with req_valid <= 1. This is allowed with B=0, including div by 0; the ALU handles it.
  - display = B.
- ISSUE:
  - req_valid=1; operand_a, operand_b and op are held constant.
  - On req_valid & req_ready: req_valid <= 0 next cycle; state <= WAIT.
  - All keys except Clear are ignored. display = B.
- WAIT:
  - On result_valid: operand_a <= result; count <= DIGITS; fresh <= 1; state <= ENTER_A; display shows result from the next cycle.
  - Keys other than Clear are ignored. result_valid in any other state is ignored.
- Clear during ISSUE with req_ready=1 in the same cycle: the transfer counts as taken by the ALU. The block still returns to ENTER_A cleared, and the later result_valid is ignored.
- Reset asserted mid-operation clears all state immediately (asynchronous), including req_valid.
- No arithmetic is done here. Operands are raw BCD nibbles, with the most recent digit in bits [3:0].

Test Plan:
- Entry: reset; value 16,20 (keys '1','2') -> display=0x0012 (DIGITS=4); then 19 (key '0') -> 0x0120.
- Leading zero and overflow: 19,19 -> display stays 0x0000; then 16,20,24,17,18 -> display=0x1234, the fifth digit is ignored.
- Full operation: 16,20, 28 (add) -> display=0x0000, op=00; 24,17 -> 0x0034; 23 (=) -> req_valid=1, a=0x0012, b=0x0034, op=00. Hold req_ready=0 for 3 cycles -> all outputs stable. req_ready=1 -> req_valid=0 next cycle, busy=1. result=0x0046 with result_valid -> display=0x0046, busy=0.
- Operator replace and chaining: after the previous result, 29 (sub) then 30 (mul) with no digits -> op=10. Enter 20, press = -> a=0x0046, b=0x0002, op=10.
- Clear during handshake: in ISSUE, assert value=27 (Clear) and req_ready=1 together -> next cycle req_valid=0, state ENTER_A, display 0. A later result_valid with result=0x9999 leaves display=0x0000.
- Async reset mid-ISSUE: drop reset_n between clock edges -> req_valid=0 immediately, display=0; invalid codes 1..15 on value cause no change.
